// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// STALL_PERF_EN (see pipeline_stall_ctrl) enables the perf counter ports.
package pipeline_ctrl_pkg;

    localparam int unsigned DEF_MEM_TIMEOUT = 255;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned PERF_W          = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        MEM  = 2'd1,
        HAZ  = 2'd2,
        BR   = 2'd3
    } stall_reason_e;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_exe_freeze;
        logic id_exe_bubble;
        logic exe_mem_freeze;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Each reason maps to one fixed control pattern; flush/freeze exclusivity follows by construction.
    function automatic stage_ctrl_t decode_reason(input stall_reason_e reason);
        stage_ctrl_t c;
        c = '0;
        case (reason)
            MEM: begin
                c.pc_freeze      = 1'b1;
                c.if_id_freeze   = 1'b1;
                c.id_exe_freeze  = 1'b1;
                c.exe_mem_freeze = 1'b1;
                c.mem_wb_bubble  = 1'b1;
            end
            HAZ: begin
                c.pc_freeze     = 1'b1;
                c.if_id_freeze  = 1'b1;
                c.id_exe_bubble = 1'b1;
            end
            BR:      c.if_id_flush = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the wait counter and perf counters.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Per-stage freeze/flush/bubble controller with memory-wait FSM and timeout watchdog.
// Define STALL_PERF_EN to add the stall_cycles / flush_count performance counters.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hazard_detected,
    input  logic br_taken,
    input  logic mem_req,
    input  logic sram_ready,
    output logic pc_freeze,
    output logic if_id_freeze,
    output logic if_id_flush,
    output logic id_exe_freeze,
    output logic id_exe_bubble,
    output logic exe_mem_freeze,
    output logic mem_wb_bubble,
    output logic mem_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
`endif
);

    ctrl_state_e        r_state;
    ctrl_state_e        w_next;
    stall_reason_e      w_reason;
    stage_ctrl_t        w_ctrl;
    logic [CNT_W-1:0]   w_wait_cnt;
    logic               w_to_err;
    logic               w_cnt_inc;
    logic               r_mem_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and stall reason; outputs are a pure decode of the reason.
    always_comb begin
        w_next   = r_state;
        w_reason = NONE;
        w_to_err = 1'b0;
        case (r_state)
            RUN: begin
                if (mem_req && !sram_ready) begin
                    w_reason = MEM;
                    w_next   = MEM_WAIT;
                end else if (hazard_detected) begin
                    w_reason = HAZ;
                end else if (br_taken) begin
                    w_reason = BR;
                end
            end
            MEM_WAIT: begin
                // A dropped mem_req is treated like completion so the pipe cannot lock up.
                if (sram_ready || !mem_req) begin
                    w_next = RUN;
                    if (hazard_detected) begin
                        w_reason = HAZ;
                    end else if (br_taken) begin
                        w_reason = BR;
                    end
                end else begin
                    w_reason = MEM;
                    if (w_wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        w_next   = ERR;
                        w_to_err = 1'b1;
                    end
                end
            end
            ERR: begin
                w_reason = MEM;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    assign w_ctrl         = decode_reason(w_reason);
    assign pc_freeze      = w_ctrl.pc_freeze;
    assign if_id_freeze   = w_ctrl.if_id_freeze;
    assign if_id_flush    = w_ctrl.if_id_flush;
    assign id_exe_freeze  = w_ctrl.id_exe_freeze;
    assign id_exe_bubble  = w_ctrl.id_exe_bubble;
    assign exe_mem_freeze = w_ctrl.exe_mem_freeze;
    assign mem_wb_bubble  = w_ctrl.mem_wb_bubble;

    // Counts cycles spent stalled on memory: 1 on entry, cleared whenever MEM_WAIT is left.
    assign w_cnt_inc = (w_next == MEM_WAIT);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cnt_inc),
        .clr   (!w_cnt_inc),
        .q     (w_wait_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_timeout <= 1'b0;
        end else if (w_to_err) begin
            r_mem_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_mem_timeout;

`ifdef STALL_PERF_EN
    sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ctrl.pc_freeze),
        .clr   (1'b0),
        .q     (stall_cycles)
    );

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_flush_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ctrl.if_id_flush),
        .clr   (1'b0),
        .q     (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (MEM_TIMEOUT=4); perf checks when STALL_PERF_EN is defined.
module tb_pipeline_stall_ctrl;

    // {pc_frz, ifid_frz, ifid_flush, idex_frz, idex_bub, exmem_frz, memwb_bub, timeout}
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_MEM  = 8'b1101_0110;
    localparam logic [7:0] E_HAZ  = 8'b1100_1000;
    localparam logic [7:0] E_BR   = 8'b0010_0000;
    localparam logic [7:0] E_ERR  = 8'b1101_0111;

    logic clk;
    logic rst_n;
    logic hazard_detected;
    logic br_taken;
    logic mem_req;
    logic sram_ready;
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_freeze;
    logic id_exe_bubble;
    logic exe_mem_freeze;
    logic mem_wb_bubble;
    logic mem_timeout;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_detected (hazard_detected),
        .br_taken        (br_taken),
        .mem_req         (mem_req),
        .sram_ready      (sram_ready),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_freeze   (id_exe_freeze),
        .id_exe_bubble   (id_exe_bubble),
        .exe_mem_freeze  (exe_mem_freeze),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout     (mem_timeout)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
    task automatic step(input logic rn, input logic hz, input logic br, input logic mr,
                        input logic sr, input logic [7:0] exp, input string name);
        @(posedge clk);
        #1;
        rst_n           = rn;
        hazard_detected = hz;
        br_taken        = br;
        mem_req         = mr;
        sram_ready      = sr;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: compare the live outputs mid-cycle against the oldest queued expectation.
    initial begin
        logic [7:0] act;
        logic [7:0] exp;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze,
                       id_exe_bubble, exe_mem_freeze, mem_wb_bubble, mem_timeout};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b", nm, act, exp);
                end
                checks++;
                if ((if_id_flush && if_id_freeze) || (id_exe_bubble && id_exe_freeze)) begin
                    failures++;
                    $display("FAIL %s_exclusive: got %b expected no flush/freeze or bubble/freeze overlap",
                             nm, act);
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        hazard_detected = 1'b0;
        br_taken        = 1'b0;
        mem_req         = 1'b0;
        sram_ready      = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "reset");
        // hazard wins over branch for two cycles
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_HAZ,  "haz_br_c1");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_HAZ,  "haz_br_c2");
        // single-cycle branch flush
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BR,   "br_flush");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "br_end");
        // three wait cycles, release on the fourth, RUN on the fifth
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "mw_c1");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, E_MEM,  "mw_c2_haz_ignored");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "mw_c3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE, "mw_release");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE, "run_single_access");
        // release cycle applies hazard rule
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "mw2_c1");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, E_HAZ,  "mw2_release_haz");
        // ready access in RUN with branch
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, E_BR,   "run_access_br");
        // mem_req dropped in MEM_WAIT behaves as release
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "drop_c1");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BR,   "drop_release_br");
        // async reset in the middle of a wait
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "rst_mid_c1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "rst_mid_c2");
        // watchdog: counter restarts from zero after reset, ERR after the fifth stalled cycle
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "to_c1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "to_c2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "to_c3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "to_c4");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "to_c5");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_ERR,  "err_entered");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, E_ERR,  "err_ignores_ready");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_ERR,  "err_sticky");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "err_reset");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BR,   "post_reset_br");
        // window for perf counters: 3 stall cycles, 2 flushes
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "perf_reset");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "perf_mw1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "perf_mw2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM,  "perf_mw3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE, "perf_release");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BR,   "perf_br1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "perf_gap");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_BR,   "perf_br2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE, "perf_idle");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

`ifdef STALL_PERF_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            failures++;
            $display("FAIL perf_stall_cycles: got %0d expected 3", stall_cycles);
        end
        checks++;
        if (flush_count !== 32'd2) begin
            failures++;
            $display("FAIL perf_flush_count: got %0d expected 2", flush_count);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
